// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU execute-stage controller.
package cpu_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 8;
    localparam int unsigned REP_WIDTH      = 4;
    localparam int unsigned OP_ALU_BIT     = 3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_CLR  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;
    localparam logic [3:0] OP_DEC  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_e;

    // Number of extra EXEC cycles beyond the first for a repeating instruction
    function automatic logic [REP_WIDTH-1:0] rep_extra(input logic [7:0] ins);
        logic [3:0] op;
        logic [3:0] imm;
        op  = ins[7:4];
        imm = ins[3:0];
        rep_extra = '0;
        if ((op == OP_INC) || (op == OP_DEC)) begin
            rep_extra = (imm == 4'd0) ? '0 : REP_WIDTH'(imm - 4'd1);
        end else if ((op == OP_SHR) || (op == OP_SHL)) begin
            rep_extra = REP_WIDTH'(imm[3:1]);
        end
    endfunction

endpackage

// File: rtl/rep_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of underflowing.
module rep_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority over decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_ctrl.sv
// Execute-stage controller: accepts one instruction, sequences accumulator
// strobes and ALU controls for one or more cycles.
// Optional macro CPU_CTRL_REPEAT_EN enables multi-cycle INC/DEC/SHR/SHL.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_ir,
    output logic                  reg_sl,
    output logic                  reg_il,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  busy,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  instr_cnt
);

    state_e               state_q;
    logic [7:0]           instr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [3:0]           op_q;
    logic [3:0]           imm_q;
    logic                 accept;
    logic                 last_c;

    assign op_q   = instr_q[7:4];
    assign imm_q  = instr_q[3:0];
    assign accept = (state_q == S_IDLE) && instr_valid;

`ifdef CPU_CTRL_REPEAT_EN
    logic rep_zero;

    rep_counter #(
        .WIDTH (REP_WIDTH)
    ) u_rep (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (rep_extra(instr)),
        .dec_i      ((state_q == S_EXEC) && !rep_zero),
        .zero_o     (rep_zero)
    );

    assign last_c = rep_zero;
`else
    assign last_c = 1'b1;
`endif

    // Controller state, latched instruction and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (last_c) begin
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                        state_q <= (op_q == OP_HALT) ? S_HALT : S_IDLE;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode of strobes from state and latched instruction
    always_comb begin
        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sr  = 1'b0;
        reg_ir  = 1'b0;
        reg_sl  = 1'b0;
        reg_il  = 1'b0;
        reg_in  = '0;
        alu_oc  = 3'b000;
        alu_b   = '0;
        if (state_q == S_EXEC) begin
            if (op_q[OP_ALU_BIT]) begin
                alu_oc = op_q[2:0];
                alu_b  = DATA_WIDTH'(imm_q);
                reg_ld = 1'b1;
                reg_in = alu_f;
            end else begin
                case (op_q)
                    OP_CLR: reg_cl = 1'b1;
                    OP_LDI: begin
                        reg_ld = 1'b1;
                        reg_in = DATA_WIDTH'(imm_q);
                    end
                    OP_INC: reg_inc = (imm_q != 4'd0);
                    OP_DEC: reg_dec = (imm_q != 4'd0);
                    OP_SHR: begin
                        reg_sr = 1'b1;
                        reg_ir = imm_q[0];
                    end
                    OP_SHL: begin
                        reg_sl = 1'b1;
                        reg_il = imm_q[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed scoreboard bench for cpu_ctrl.
module tb_cpu_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] alu_f;
    logic [2:0] alu_oc;
    logic [3:0] alu_b;
    logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
    logic [3:0] reg_in;
    logic       busy;
    logic       halted;
    logic [7:0] instr_cnt;

    int         tests;
    int         fails;
    logic [7:0] exp_cnt;
    logic [18:0] sb[$];
    logic [18:0] dut_vec;

`ifdef CPU_CTRL_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    cpu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_f       (alu_f),
        .alu_oc      (alu_oc),
        .alu_b       (alu_b),
        .reg_cl      (reg_cl),
        .reg_ld      (reg_ld),
        .reg_inc     (reg_inc),
        .reg_dec     (reg_dec),
        .reg_sr      (reg_sr),
        .reg_ir      (reg_ir),
        .reg_sl      (reg_sl),
        .reg_il      (reg_il),
        .reg_in      (reg_in),
        .busy        (busy),
        .halted      (halted),
        .instr_cnt   (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_vec = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il,
                      alu_oc, alu_b, reg_in};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: number of EXEC cycles and the strobe vector held in each
    task automatic model(input logic [7:0] ins, input logic [3:0] fv,
                         output int n, output logic [18:0] v);
        logic [3:0] op, imm;
        logic cl, ld, inc, dec, sr, ir, sl, il;
        logic [2:0] oc;
        logic [3:0] b, rin;
        op = ins[7:4]; imm = ins[3:0];
        {cl, ld, inc, dec, sr, ir, sl, il} = 8'h00;
        oc = 3'b000; b = 4'h0; rin = 4'h0;
        n = 1;
        if (op >= 4'h8) begin
            oc = op[2:0]; b = imm; ld = 1'b1; rin = fv;
        end else begin
            case (op)
                4'h1: cl = 1'b1;
                4'h2: begin ld = 1'b1; rin = imm; end
                4'h3, 4'h4: begin
                    if (imm != 4'h0) begin
                        if (op == 4'h3) inc = 1'b1; else dec = 1'b1;
                        n = REP ? int'(imm) : 1;
                    end
                end
                4'h5, 4'h6: begin
                    if (op == 4'h5) begin sr = 1'b1; ir = imm[0]; end
                    else begin sl = 1'b1; il = imm[0]; end
                    n = REP ? int'(imm[3:1]) + 1 : 1;
                end
                default: ;
            endcase
        end
        v = {cl, ld, inc, dec, sr, ir, sl, il, oc, b, rin};
    endtask

    // Issue one instruction from a negedge where the DUT is idle; returns at a negedge
    task automatic send(input logic [7:0] ins, input logic [3:0] fv, input bit hold);
        int n;
        int cyc;
        logic [18:0] v;
        logic [18:0] e;
        model(ins, fv, n, v);
        chk("ready_before_accept", 32'(instr_ready), 32'd1);
        instr = ins; alu_f = fv; instr_valid = 1'b1;
        for (int i = 0; i < n; i++) sb.push_back(v);
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
        cyc = 0;
        while (busy && cyc <= 40) begin
            chk("ready_low_while_busy", 32'(instr_ready), 32'd0);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("strobes_%02h_c%0d", ins, cyc), 32'(dut_vec), 32'(e));
            end
            cyc++;
            @(negedge clk);
        end
        chk("exec_within_budget", 32'(cyc <= 40), 32'd1);
        chk($sformatf("sb_drained_%02h", ins), 32'(sb.size()), 32'd0);
        sb.delete();
        exp_cnt = exp_cnt + 8'd1;
        chk($sformatf("instr_cnt_%02h", ins), 32'(instr_cnt), 32'(exp_cnt));
        chk("halted_after", 32'(halted), 32'(ins[7:4] == 4'h7));
        chk("ready_after", 32'(instr_ready), 32'(ins[7:4] != 4'h7));
        chk("strobes_idle", 32'(dut_vec), 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0; exp_cnt = 8'd0;
        rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0; alu_f = 4'h0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        chk("rst_strobes", 32'(dut_vec), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back with valid held, then the main opcode classes
        send(8'h2A, 4'h0, 1'b1);
        send(8'h10, 4'h0, 1'b0);
        send(8'h33, 4'h0, 1'b0);
        send(8'h42, 4'h0, 1'b0);
        send(8'h5B, 4'h0, 1'b0);
        send(8'h65, 4'h0, 1'b0);
        send(8'h30, 4'h0, 1'b0);
        send(8'h4F, 4'h0, 1'b0);
        send(8'h00, 4'h0, 1'b0);
        send(8'hB6, 4'h9, 1'b0);
        send(8'h8F, 4'h3, 1'b1);
        send(8'hF1, 4'hC, 1'b0);

        // HALT is sticky against further valid instructions
        send(8'h70, 4'h0, 1'b0);
        instr = 8'h21; instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_ready", 32'(instr_ready), 32'd0);
            chk("halt_strobes", 32'(dut_vec), 32'd0);
            chk("halt_cnt", 32'(instr_cnt), 32'(exp_cnt));
        end
        #2 rst_n = 1'b0; instr_valid = 1'b0; exp_cnt = 8'd0;
        #1;
        chk("halt_rst_cnt", 32'(instr_cnt), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_halt_ready", 32'(instr_ready), 32'd1);
        chk("post_halt_cnt", 32'(instr_cnt), 32'd0);

        // Reset in the middle of a repeating INC
        instr = 8'h35; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_inc_c0", 32'(reg_inc), 32'd1);
        if (REP) begin
            @(negedge clk);
            chk("mid_inc_c1", 32'(reg_inc), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'(dut_vec), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt", 32'(instr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", 32'(instr_ready), 32'd1);
        chk("mid_rel_cnt", 32'(instr_cnt), 32'd0);

        // Counter wraps from 255 to 0
        for (int i = 0; i < 256; i++) send(8'h00, 4'h0, 1'b0);
        chk("cnt_wrap", 32'(instr_cnt), 32'd0);
        send(8'h21, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Execute-stage controller for the 4-bit CPU datapath. It accepts one 8-bit instruction at a time over a valid/ready handshake and decodes it. It then sequences the control strobes of the accumulator register (clear, load, increment, decrement, shift) and the opcode and operand of the ALU for one or more cycles. It sits directly upstream of the ALU and the accumulator register, which consume every control output it produces.

## Interface
- DATA_WIDTH, 4, width of the accumulator, immediate and ALU operands
- CNT_WIDTH, 8, width of the retired-instruction counter
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- instr  input  8  instruction word {op[7:4], imm[3:0]}
- instr_valid  input  1  instr is valid this cycle
- instr_ready  output  1  controller accepts instr this cycle
- alu_f  input  DATA_WIDTH  ALU result (ALU operand a is wired externally to the accumulator output)
- alu_oc  output  3  ALU opcode
- alu_b  output  DATA_WIDTH  ALU operand b
- reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  output  1 each  accumulator control strobes
- reg_in  output  DATA_WIDTH  accumulator load data
- busy  output  1  an instruction is executing
- halted  output  1  HALT was executed
- instr_cnt  output  CNT_WIDTH  count of retired instructions, wraps modulo 2^CNT_WIDTH

## Operation
States: IDLE, EXEC, HALT.
- Reset: all outputs are 0 except instr_ready, which is 1. Counters are 0. State is IDLE.
- IDLE: instr_ready=1. When instr_valid is high, the instruction and a repeat count are latched and the state goes to EXEC.
- EXEC: strobes assert while rep>0, then rep decrements. When the last cycle completes, the controller returns to IDLE and instr_cnt increments.
- HALT: instr_ready=0, halted=1 and all strobes are 0. Only reset leaves this state.

Opcodes:
- 0x0 NOP: one EXEC cycle, no strobes.
- 0x1 CLR: reg_cl for one cycle.
- 0x2 LDI: reg_ld=1 and reg_in=imm for one cycle.
- 0x3 INC and 0x4 DEC: reg_inc or reg_dec for imm cycles. imm=0 gives one EXEC cycle with no strobe.
- 0x5 SHR: reg_sr with reg_ir=imm[0] for imm[3:1]+1 cycles.
- 0x6 SHL: reg_sl with reg_il=imm[0] for imm[3:1]+1 cycles.
- 0x7 HALT: one EXEC cycle with no strobes. instr_cnt increments, then the state goes to HALT.
- 0x8–0xF ALU: one cycle with alu_oc=op[2:0], alu_b=imm, reg_ld=1 and reg_in=alu_f.

Output rules:
- At most one of cl, ld, inc, dec, sr and sl is high in any cycle.
- reg_ir and reg_il are 0 except during their own shift.
- alu_oc and alu_b are 0 outside ALU-class EXEC cycles.

## Timing
- Handshake: a transfer occurs on the rising edge where instr_valid && instr_ready. instr_ready depends only on state, with no combinational path from instr_valid.
- Latency: for an instruction accepted at edge T, strobes are high in the cycle after T. They are sampled by the accumulator register at edge T+1 … T+N, where N is the repeat count, with a minimum of 1.
- busy is 1 exactly during EXEC. instr_ready returns to 1 in the cycle after the last EXEC cycle, so back-to-back throughput is one instruction per N+1 cycles.
- All strobes are Moore outputs of state and the latched instruction. reg_in during ALU ops is the only input-to-output combinational path (alu_f→reg_in).
- instr_cnt increments on the final EXEC edge and wraps from 255 to 0.
- Reset asserted mid-EXEC clears all strobes immediately (asynchronously), and the partially executed instruction is not counted.
- When a repeat count reaches 0 the controller leaves EXEC. It never underflows.

## Configuration
- CPU_CTRL_REPEAT_EN defined: repeat counts for INC, DEC, SHR and SHL apply as specified above.
- Macro undefined:
  - INC and DEC with imm≠0 run for exactly one cycle; imm=0 still gives no strobe.
  - SHR and SHL run for exactly one cycle regardless of imm[3:1].
  - The repeat counter is not instantiated.

## Structure
- Shared package cpu_pkg holds:
  - the opcode constants (OP_NOP … OP_HALT, and OP_ALU_BIT = op[3])
  - the state encoding (S_IDLE, S_EXEC, S_HALT)
  - the DATA_WIDTH default
- One sub-module, rep_counter: a loadable down-counter with a zero flag. It is instantiated only under CPU_CTRL_REPEAT_EN.

## Test plan
- Reset, then LDI 0x2A with valid held → instr_ready drops for 1 cycle. reg_ld=1 and reg_in=0xA in the cycle after accept. instr_cnt=1.
- INC 0x33 → reg_inc is high for 3 consecutive cycles and busy for 3. Without the macro, reg_inc is high for 1 cycle.
- SHL 0x65 (imm[3:1]=2, il=1) → reg_sl=1 and reg_il=1 for 3 cycles.
- ALU op 0xB6 with alu_f driven to 0x9 → alu_oc=3'b011, alu_b=0x6, reg_ld=1 and reg_in=0x9 for 1 cycle.
- HALT 0x70, then valid held with 0x21 → halted=1 and instr_ready stays 0 for 20 cycles with no strobes. After a rst_n pulse, IDLE with instr_cnt=0.
- rst_n asserted in the 2nd cycle of INC 0x35 → strobes 0 immediately, instr_cnt unchanged at 0, instr_ready=1 after release.
